fetch_unit: RTL and testbench

- Instruction-fetch stage of the single-cycle processor. Sits directly upstream of decode and the immediate generator.
- Holds the PC and issues one outstanding read at a time to instruction memory.
- Presents the fetched instruction word and its PC to decode over a valid/ready handshake.
- Accepts redirects (branch/jal/jalr targets) from execute, with squash of in-flight responses and a misalignment fault.

---
 rtl/fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues one outstanding imem read at a time and
// hands each word to decode over valid/ready; redirects squash in-flight reads or fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        squash_q, squash_d;
  logic        outstanding_q, outstanding_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        target_misaligned;

  assign target_misaligned = (redirect_target[1:0] != 2'b00);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    squash_d      = squash_q;
    outstanding_d = outstanding_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    fetch_fault_d = fetch_fault_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        if (redirect_valid) begin
          if (target_misaligned) begin
            fetch_fault_d = 1'b1;
            outstanding_d = imem_gnt;
            state_d       = FAULT;
          end else begin
            // A grant coinciding with the redirect is already in flight: squash it.
            pc_d     = redirect_target;
            squash_d = imem_gnt;
            state_d  = imem_gnt ? WAIT : REQ;
          end
        end else if (imem_gnt) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          if (target_misaligned) begin
            fetch_fault_d = 1'b1;
            outstanding_d = !imem_rvalid;
            squash_d      = 1'b0;
            state_d       = FAULT;
          end else begin
            pc_d     = redirect_target;
            squash_d = !imem_rvalid;
            state_d  = imem_rvalid ? REQ : WAIT;
          end
        end else if (imem_rvalid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = REQ;
          end else begin
            instr_out_d = imem_rdata;
            instr_pc_d  = pc_q;
            pc_d        = pc_q + 32'd4;
            state_d     = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          instr_out_d = NOP_INSTR;
          if (target_misaligned) begin
            fetch_fault_d = 1'b1;
            outstanding_d = 1'b0;
            state_d       = FAULT;
          end else begin
            pc_d    = redirect_target;
            state_d = REQ;
          end
        end else if (instr_ready) begin
          fetch_count_d = fetch_count_q + 32'd1;
          instr_out_d   = NOP_INSTR;
          state_d       = REQ;
        end
      end

      FAULT: begin
        if (imem_rvalid) begin
          outstanding_d = 1'b0;
        end
        if (redirect_valid && !target_misaligned) begin
          fetch_fault_d = 1'b0;
          pc_d          = redirect_target;
          if (outstanding_q && !imem_rvalid) begin
            squash_d = 1'b1;
            state_d  = WAIT;
          end else begin
            state_d = REQ;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    imem_req_d    = (state_d == REQ);
    instr_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      squash_q      <= 1'b0;
      outstanding_q <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_out_q   <= NOP_INSTR;
      instr_pc_q    <= RESET_PC;
      fetch_fault_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      squash_q      <= squash_d;
      outstanding_q <= outstanding_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      fetch_fault_q <= fetch_fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_fault = fetch_fault_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle vector table for reset/basic fetch/stall, then hand sequences
// for redirect, fault, PC wrap and mid-transaction reset, with a fetch scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] IA  = 32'h0050_0093;
  localparam logic [31:0] IB  = 32'h00A0_0113;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [31:0] exp_addr;
  logic [31:0] exp_count;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .fetch_fault    (fetch_fault),
    .fetch_count    (fetch_count)
  );

  typedef struct packed {
    bit        rst;
    bit        gnt;
    bit        rv;
    bit [31:0] rd;
    bit        rdy;
    bit        e_req;
    bit [31:0] e_addr;
    bit        e_iv;
    bit [31:0] e_out;
    bit [31:0] e_pc;
    bit [31:0] e_cnt;
  } vec_t;

  vec_t vecs [0:15];

  function automatic vec_t mk(input bit rst, input bit gnt, input bit rv, input bit [31:0] rd,
                              input bit rdy, input bit e_req, input bit [31:0] e_addr,
                              input bit e_iv, input bit [31:0] e_out, input bit [31:0] e_pc,
                              input bit [31:0] e_cnt);
    vec_t v;
    v.rst = rst;  v.gnt = gnt;  v.rv = rv;  v.rd = rd;  v.rdy = rdy;
    v.e_req = e_req;  v.e_addr = e_addr;  v.e_iv = e_iv;
    v.e_out = e_out;  v.e_pc = e_pc;  v.e_cnt = e_cnt;
    return v;
  endfunction

  // Instruction memory contents as a function of word address.
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic drive(input bit g, input bit rv, input logic [31:0] rd,
                       input bit rdv, input logic [31:0] rdt, input bit rdy);
    imem_gnt        = g;
    imem_rvalid     = rv;
    imem_rdata      = rd;
    redirect_valid  = rdv;
    redirect_target = rdt;
    instr_ready     = rdy;
  endtask

  // Memory answers every request with a grant and returns data one cycle later.
  task automatic stream(input int unsigned n, input bit stall);
    int unsigned done = 0;
    bit          pend = 1'b0;
    logic [31:0] pdata = '0;
    logic [63:0] e;
    bit          rdy;
    for (int unsigned cyc = 0; cyc < 200 && done < n; cyc++) begin
      @(negedge clk);
      chk32("stream fetch_count", fetch_count, exp_count);
      chk1("stream fault", fetch_fault, 1'b0);
      rdy = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive(1'b1, pend, pend ? pdata : 32'h0, 1'b0, 32'h0, rdy);
      pend = 1'b0;
      if (imem_req) begin
        chk32("stream imem_addr", imem_addr, exp_addr);
        sb.push_back({exp_addr, word(exp_addr)});
        pend     = 1'b1;
        pdata    = word(exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
      if (instr_valid && rdy) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stream scoreboard: instruction %h with nothing expected", instr_out);
        end else begin
          e = sb.pop_front();
          chk32("stream instr_pc", instr_pc, e[63:32]);
          chk32("stream instr_out", instr_out, e[31:0]);
        end
        exp_count = exp_count + 32'd1;
        done++;
      end
    end
    n_checks++;
    if (done < n) begin
      n_fail++;
      $display("FAIL stream timeout: got %0d instructions, expected %0d", done, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(0, 0, 0, 0,  0, 0, 32'h0, 0, NOP, 32'h0, 0);
    vecs[1]  = mk(1, 1, 0, 0,  0, 0, 32'h0, 0, NOP, 32'h0, 0);
    vecs[2]  = mk(1, 1, 0, 0,  0, 1, 32'h0, 0, NOP, 32'h0, 0);
    vecs[3]  = mk(1, 1, 1, IA, 0, 0, 32'h0, 0, NOP, 32'h0, 0);
    for (int i = 4; i <= 8; i++) vecs[i] = mk(1, 1, 0, 0, 0, 0, 32'h4, 1, IA, 32'h0, 0);
    vecs[9]  = mk(1, 0, 0, 0,  1, 0, 32'h4, 1, IA,  32'h0, 0);
    vecs[10] = mk(1, 1, 0, 0,  0, 1, 32'h4, 0, NOP, 32'h0, 1);
    vecs[11] = mk(1, 1, 0, 0,  0, 0, 32'h4, 0, NOP, 32'h0, 1);
    vecs[12] = mk(1, 0, 1, IB, 0, 0, 32'h4, 0, NOP, 32'h0, 1);
    vecs[13] = mk(1, 0, 0, 0,  1, 0, 32'h8, 1, IB,  32'h4, 1);
    vecs[14] = mk(1, 0, 0, 0,  0, 1, 32'h8, 0, NOP, 32'h4, 2);
    vecs[15] = mk(1, 0, 0, 0,  0, 1, 32'h8, 0, NOP, 32'h4, 2);

    #1 rst_n = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk1 ($sformatf("v%0d imem_req", i),    imem_req,    vecs[i].e_req);
      chk32($sformatf("v%0d imem_addr", i),   imem_addr,   vecs[i].e_addr);
      chk1 ($sformatf("v%0d instr_valid", i), instr_valid, vecs[i].e_iv);
      chk32($sformatf("v%0d instr_out", i),   instr_out,   vecs[i].e_out);
      chk32($sformatf("v%0d instr_pc", i),    instr_pc,    vecs[i].e_pc);
      chk1 ($sformatf("v%0d fetch_fault", i), fetch_fault, 1'b0);
      chk32($sformatf("v%0d fetch_count", i), fetch_count, vecs[i].e_cnt);
      rst_n = vecs[i].rst;
      drive(vecs[i].gnt, vecs[i].rv, vecs[i].rd, 1'b0, 32'h0, vecs[i].rdy);
    end
    exp_count = 32'd2;

    // Redirect while waiting; the late response must be dropped.
    @(negedge clk);
    chk1("A req", imem_req, 1'b1);
    chk32("A addr", imem_addr, 32'h8);
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk1("A wait req", imem_req, 1'b0);
    drive(0, 0, 0, 1, 32'h100, 0);
    @(negedge clk);
    chk32("A redirected addr", imem_addr, 32'h100);
    chk1("A no req", imem_req, 1'b0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk1("A still waiting", imem_req, 1'b0);
    drive(0, 1, 32'hDEAD_BEEF, 0, 0, 1);
    @(negedge clk);
    chk1("A reissue req", imem_req, 1'b1);
    chk32("A reissue addr", imem_addr, 32'h100);
    chk1("A squashed valid", instr_valid, 1'b0);
    chk32("A squashed out", instr_out, NOP);
    drive(0, 0, 0, 0, 0, 0);
    exp_addr = 32'h100;
    stream(1, 1'b0);

    // Misaligned redirect: sticky fault, no requests, exit by aligned redirect.
    @(negedge clk);
    chk1("B req", imem_req, 1'b1);
    chk32("B addr", imem_addr, 32'h104);
    drive(0, 0, 0, 1, 32'h102, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1($sformatf("B%0d fault", i), fetch_fault, 1'b1);
      chk1($sformatf("B%0d req", i), imem_req, 1'b0);
      chk1($sformatf("B%0d valid", i), instr_valid, 1'b0);
      drive(1, (i == 2), 32'h0BAD_0013, 0, 0, 1);
    end
    @(negedge clk);
    chk1("B fault held", fetch_fault, 1'b1);
    chk32("B pc unchanged", imem_addr, 32'h104);
    drive(0, 0, 0, 1, 32'h200, 0);
    @(negedge clk);
    chk1("B fault cleared", fetch_fault, 1'b0);
    chk1("B req resumed", imem_req, 1'b1);
    chk32("B new addr", imem_addr, 32'h200);
    drive(0, 0, 0, 0, 0, 0);
    exp_addr = 32'h200;
    stream(2, 1'b1);

    // Redirect in HOLD with ready high: held instruction dropped, not counted.
    @(negedge clk);
    chk1("C req", imem_req, 1'b1);
    chk32("C addr", imem_addr, 32'h208);
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 32'hCAFE_0013, 0, 0, 0);
    @(negedge clk);
    chk1("C valid", instr_valid, 1'b1);
    chk32("C out", instr_out, 32'hCAFE_0013);
    chk32("C pc", instr_pc, 32'h208);
    drive(0, 0, 0, 1, 32'hFFFF_FFF8, 1);
    @(negedge clk);
    chk1("C dropped valid", instr_valid, 1'b0);
    chk32("C dropped out", instr_out, NOP);
    chk32("C count unchanged", fetch_count, exp_count);
    chk1("C req", imem_req, 1'b1);
    chk32("C redirected addr", imem_addr, 32'hFFFF_FFF8);
    drive(0, 0, 0, 0, 0, 0);
    exp_addr = 32'hFFFF_FFF8;
    stream(3, 1'b1);

    // Reset during WAIT, then a stale response after release.
    @(negedge clk);
    chk1("D req", imem_req, 1'b1);
    chk32("D addr wrapped", imem_addr, 32'h4);
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk1("D waiting", imem_req, 1'b0);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk1("D rst req", imem_req, 1'b0);
    chk32("D rst addr", imem_addr, 32'h0);
    chk1("D rst valid", instr_valid, 1'b0);
    chk32("D rst out", instr_out, NOP);
    chk32("D rst pc", instr_pc, 32'h0);
    chk1("D rst fault", fetch_fault, 1'b0);
    chk32("D rst count", fetch_count, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 32'hBAD0_0013, 0, 0, 1);
    @(negedge clk);
    chk1("D first req", imem_req, 1'b1);
    chk32("D first addr", imem_addr, 32'h0);
    chk1("D stale valid", instr_valid, 1'b0);
    drive(0, 1, 32'hBAD0_0013, 0, 0, 1);
    @(negedge clk);
    chk1("D still req", imem_req, 1'b1);
    chk32("D still addr", imem_addr, 32'h0);
    chk1("D stale ignored", instr_valid, 1'b0);
    chk32("D stale out", instr_out, NOP);
    chk32("D count", fetch_count, 32'h0);
    drive(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
